// File: rtl/scroll_band.sv
// Scrolling-band renderer: a BAND_ROWS x PERIOD bit pattern, tiled horizontally,
// scrolled once per frame with a speed ramp, pause and run-time pattern load.
module scroll_band #(
  parameter int unsigned BAND_TOP     = 400,
  parameter int unsigned BAND_ROWS    = 8,
  parameter int unsigned PERIOD       = 160,
  parameter int unsigned SPD_W        = 4,
  parameter int unsigned SPEED_INIT   = 4,
  parameter int unsigned SPEED_MAX    = 12,
  parameter int unsigned ACCEL_FRAMES = 600,
  localparam int unsigned RW = (BAND_ROWS > 1) ? $clog2(BAND_ROWS) : 1,
  localparam int unsigned PW = $clog2(PERIOD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        row_addr,
  input  logic [9:0]        col_addr,
  input  logic              fresh,
  input  logic              game_status,
  input  logic              pause,
  input  logic              pat_we,
  input  logic [RW-1:0]     pat_row,
  input  logic [PERIOD-1:0] pat_data,
  output logic              px,
  output logic [PW-1:0]     scroll_pos,
  output logic [SPD_W-1:0]  speed,
  output logic              running
);

  localparam int unsigned CW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_e;

  state_e             state_q;
  logic               running_q;
  logic               fresh_q;
  logic               tick;
  logic [PW-1:0]      scroll_q, scroll_d;
  logic [SPD_W-1:0]   speed_q, speed_d;
  logic [CW-1:0]      cnt_q;
  logic [PW:0]        scroll_sum;

  logic [PERIOD-1:0]  pat_q [BAND_ROWS];

  logic [8:0]         prow_d;
  logic               in_band_d, in_band_q;
  logic [RW-1:0]      prow_q;
  logic [10:0]        idx_sum;
  logic [PW-1:0]      idx_d, idx_q;
  logic               px_q;

  assign tick = fresh_q & ~fresh;

  // Next scroll offset (single wrap) and saturating speed increment
  always_comb begin
    scroll_sum = {1'b0, scroll_q} + (PW+1)'(speed_q);
    scroll_d   = PW'(scroll_sum);
    if (scroll_sum >= (PW+1)'(PERIOD)) scroll_d = PW'(scroll_sum - (PW+1)'(PERIOD));
    speed_d = speed_q;
    if (speed_q < SPD_W'(SPEED_MAX)) speed_d = speed_q + SPD_W'(1);
  end

  // Frame-strobe edge detector
  always_ff @(posedge clk) begin
    if (rst) fresh_q <= 1'b0;
    else     fresh_q <= fresh;
  end

  // Game FSM with scroll advance and speed ramp on frame ticks while running
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      scroll_q  <= '0;
      speed_q   <= SPD_W'(SPEED_INIT);
      cnt_q     <= '0;
    end else if (!game_status) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      speed_q   <= SPD_W'(SPEED_INIT);
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end
        ST_RUN: begin
          if (pause) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
          if (tick) begin
            scroll_q <= scroll_d;
            if (ACCEL_FRAMES != 0) begin
              if (cnt_q == CW'(ACCEL_FRAMES - 1)) begin
                cnt_q   <= '0;
                speed_q <= speed_d;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Pattern store: row 0 solid after reset, rows written at run time
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < BAND_ROWS; r++) begin
        if (r == 0) pat_q[r] <= '1;
        else        pat_q[r] <= '0;
      end
    end else if (pat_we && (32'(pat_row) < BAND_ROWS)) begin
      pat_q[pat_row] <= pat_data;
    end
  end

  // Stage-1 address decode: band membership, pattern row, wrapped column
  always_comb begin
    prow_d    = row_addr - 9'(BAND_TOP);
    in_band_d = prow_d < 9'(BAND_ROWS);
    idx_sum   = {1'b0, col_addr} + 11'(scroll_q);
    idx_d     = PW'(idx_sum % 11'(PERIOD));
  end

  // Two-stage pixel pipe: register decode, then look up the pattern bit
  always_ff @(posedge clk) begin
    if (rst) begin
      in_band_q <= 1'b0;
      prow_q    <= '0;
      idx_q     <= '0;
      px_q      <= 1'b0;
    end else begin
      in_band_q <= in_band_d;
      prow_q    <= prow_d[RW-1:0];
      idx_q     <= idx_d;
      px_q      <= in_band_q ? pat_q[prow_q][idx_q] : 1'b0;
    end
  end

  assign px         = px_q;
  assign scroll_pos = scroll_q;
  assign speed      = speed_q;
  assign running    = running_q;

endmodule

// File: tb/tb_scroll_band.sv
// Scoreboard bench for scroll_band: two instances (default ramp, fast ramp),
// expectations queued by stimulus and popped by a monitor on the falling edge.
module tb_scroll_band;

  localparam int K_SCR = 0;
  localparam int K_SPD = 1;
  localparam int K_RUN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, fresh, gs_a, gs_b, pause, pat_we;
  logic [8:0]   row_addr;
  logic [9:0]   col_addr;
  logic [2:0]   pat_row;
  logic [159:0] pat_data;
  logic         px_a, px_b, run_a, run_b;
  logic [7:0]   sp_a, sp_b;
  logic [3:0]   spd_a, spd_b;

  scroll_band dut_a (
    .clk(clk), .rst(rst), .row_addr(row_addr), .col_addr(col_addr),
    .fresh(fresh), .game_status(gs_a), .pause(pause), .pat_we(pat_we),
    .pat_row(pat_row), .pat_data(pat_data), .px(px_a), .scroll_pos(sp_a),
    .speed(spd_a), .running(run_a)
  );

  scroll_band #(.ACCEL_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .row_addr(row_addr), .col_addr(col_addr),
    .fresh(fresh), .game_status(gs_b), .pause(pause), .pat_we(pat_we),
    .pat_row(pat_row), .pat_data(pat_data), .px(px_b), .scroll_pos(sp_b),
    .speed(spd_b), .running(run_b)
  );

  typedef struct {
    int dut;
    int kind;
    int val;
  } rexp_t;

  rexp_t      rq[$];
  int         pq[$];
  logic       px_req  = 1'b0;
  logic       chk_req = 1'b0;
  logic [1:0] pv      = 2'b00;
  int         npass   = 0;
  int         ntotal  = 0;

  function automatic int actual(int d, int k);
    case (k)
      K_SCR:   return (d == 0) ? int'(sp_a)  : int'(sp_b);
      K_SPD:   return (d == 0) ? int'(spd_a) : int'(spd_b);
      default: return (d == 0) ? int'(run_a) : int'(run_b);
    endcase
  endfunction

  function automatic string kname(int k);
    case (k)
      K_SCR:   return "scroll_pos";
      K_SPD:   return "speed";
      default: return "running";
    endcase
  endfunction

  // pixel request latency shadow: px answers two edges after the request
  always @(posedge clk) pv <= {pv[0], px_req};

  always @(negedge clk) begin : mon
    int    e;
    int    a;
    rexp_t r;
    if (pv[1]) begin
      ntotal++;
      if (pq.size() == 0) begin
        $display("FAIL px: no expectation queued, got %0d", px_a);
      end else begin
        e = pq.pop_front();
        if (int'(px_a) == e) npass++;
        else $display("FAIL px @%0t: got %0d want %0d", $time, px_a, e);
      end
    end
    if (chk_req) begin
      while (rq.size() > 0) begin
        r = rq.pop_front();
        a = actual(r.dut, r.kind);
        ntotal++;
        if (a == r.val) npass++;
        else $display("FAIL %s[dut_%s] @%0t: got %0d want %0d",
                      kname(r.kind), (r.dut == 0) ? "a" : "b", $time, a, r.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic chk(input int d, input int k, input int v);
    rexp_t e;
    e.dut = d; e.kind = k; e.val = v;
    rq.push_back(e);
    chk_req = 1'b1;
  endtask

  task automatic pix(input int r, input int c, input int e);
    row_addr = 9'(r);
    col_addr = 10'(c);
    pq.push_back(e);
    px_req = 1'b1;
    step();
    px_req = 1'b0;
  endtask

  task automatic tick();
    fresh = 1'b1;
    step();
    fresh = 1'b0;
    step();
  endtask

  int ea[6] = '{4, 8, 12, 16, 20, 24};
  int eb[6] = '{4, 8, 13, 18, 24, 30};

  initial begin
    rst = 1'b1; fresh = 1'b0; gs_a = 1'b0; gs_b = 1'b0; pause = 1'b0;
    pat_we = 1'b0; pat_row = '0; pat_data = '0; row_addr = '0; col_addr = '0;
    step(); step();
    for (int d = 0; d < 2; d++) begin
      chk(d, K_SCR, 0); chk(d, K_SPD, 4); chk(d, K_RUN, 0);
    end
    rst = 1'b0;
    step();

    // default pattern, scroll 0: only row 400 (pattern row 0) is lit
    pix(400, 0, 1); pix(400, 77, 1); pix(400, 1023, 1); pix(401, 5, 0);
    pix(399, 0, 0); pix(408, 0, 0); pix(407, 3, 0); pix(0, 0, 0);

    gs_a = 1'b1; gs_b = 1'b1;
    step();
    chk(0, K_RUN, 1); chk(1, K_RUN, 1);

    for (int i = 0; i < 6; i++) begin
      tick();
      chk(0, K_SCR, ea[i]); chk(1, K_SCR, eb[i]);
      if (i == 2) chk(0, K_SPD, 4);
    end
    chk(0, K_SPD, 4); chk(1, K_SPD, 7); chk(0, K_RUN, 1);

    // tick on the same edge as game stop on dut_b: no advance there
    fresh = 1'b1; step();
    fresh = 1'b0; gs_b = 1'b0; step();
    chk(1, K_SCR, 30); chk(1, K_SPD, 4); chk(1, K_RUN, 0); chk(0, K_SCR, 28);

    gs_b = 1'b1;
    step();
    chk(1, K_RUN, 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk(1, K_SPD, (4 + k / 2 > 12) ? 12 : 4 + k / 2);
      if (k == 16) chk(1, K_SCR, 150);
      if (k == 17) chk(1, K_SCR, 2);
      if (k == 20) chk(1, K_SCR, 38);
    end
    chk(0, K_SCR, 108); chk(0, K_SPD, 4);

    gs_b = 1'b0;
    step();
    chk(1, K_SPD, 4); chk(1, K_SCR, 38); chk(1, K_RUN, 0);

    repeat (12) tick();
    chk(0, K_SCR, 156);
    tick();
    chk(0, K_SCR, 0);

    pause = 1'b1;
    step();
    chk(0, K_RUN, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(0, K_SCR, 0); chk(0, K_SPD, 4);
    end
    pause = 1'b0;
    step();
    chk(0, K_RUN, 1);
    tick();
    chk(0, K_SCR, 4);

    // pattern row 2 = bit 5 only; scroll 4 so col 1 and col 161 map to bit 5
    pat_data = '0;
    pat_data[5] = 1'b1;
    pat_row = 3'd2;
    pix(402, 1, 0);
    pat_we = 1'b1;
    pix(402, 1, 1);
    pat_we = 1'b0;
    pix(402, 2, 0); pix(402, 161, 1); pix(402, 0, 0);
    pix(400, 50, 1); pix(403, 1, 0);
    repeat (3) step();

    // reset coincident with a tick while running
    fresh = 1'b1; step();
    fresh = 1'b0; rst = 1'b1; step();
    for (int d = 0; d < 2; d++) begin
      chk(d, K_SCR, 0); chk(d, K_SPD, 4); chk(d, K_RUN, 0);
    end
    rst = 1'b0;
    step();
    pix(402, 1, 0); pix(400, 1, 1); pix(402, 5, 0);

    for (int i = 0; i < 50 && (pq.size() > 0 || rq.size() > 0); i++) step();
    if (pq.size() > 0 || rq.size() > 0) begin
      $display("FAIL drain: %0d px and %0d register expectations left unchecked",
               pq.size(), rq.size());
      ntotal = ntotal + pq.size() + rq.size();
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
